elelock3: RTL and testbench

- Parametrised successor to the team's fixed 4-digit electronic lock.
- Accepts one-hot ten-key presses and keeps a shift register of the last DIGITS digits.
- In OPEN state, close latches that shift register as the secret code and locks the door. In LOCKED state, each complete DIGITS-long entry is checked against the secret.
- New features: per-press edge detection, attempt counting, MAX_FAIL lockout with timed alarm, and a reject flag for invalid close requests.

---
 rtl/elelock_pkg.sv | 26 ++
 rtl/tenkey_dec.sv | 25 ++
 rtl/elelock3.sv | 127 ++++++++++++
 tb/tb_elelock3.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elelock_pkg.sv
// Shared types and key-pad helpers for the parametrised electronic lock.
package elelock_pkg;

  typedef enum logic [1:0] {
    OPEN    = 2'd0,
    LOCKED  = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  localparam logic [3:0] NO_DIGIT = 4'hF;

  // Highest set bit wins; callers only use the result when the input is one-hot.
  function automatic logic [3:0] onehot10_to_bcd(input logic [9:0] v);
    logic [3:0] r;
    r = NO_DIGIT;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic is_onehot10(input logic [9:0] v);
    return $onehot(v);
  endfunction

endpackage

// File: rtl/tenkey_dec.sv
// Ten-key front end: rising-edge press detection and BCD encoding of the pressed key.
module tenkey_dec
  import elelock_pkg::*;
(
  input  logic       ck,
  input  logic       reset,
  input  logic [9:0] tenkey,
  output logic       valid,
  output logic [3:0] digit
);

  logic [9:0] tenkey_q;
  logic [9:0] press;

  always_ff @(posedge ck) begin
    if (reset) tenkey_q <= '0;
    else       tenkey_q <= tenkey;
  end

  // A new key edge counts only when the pad itself shows a single key.
  assign press = tenkey & ~tenkey_q;
  assign valid = is_onehot10(press) && is_onehot10(tenkey);
  assign digit = onehot10_to_bcd(tenkey);

endmodule

// File: rtl/elelock3.sv
// Electronic lock: code entry shift register, secret latch, failure counting and timed lockout.
module elelock3
  import elelock_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic       ck,
  input  logic       reset,
  input  logic [9:0] tenkey,
  input  logic       close,
  output logic       lock,
  output logic       alarm,
  output logic       reject,
  output logic [3:0] digit_cnt
);

  localparam int KW = 4 * DIGITS;
  localparam int TW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [KW-1:0] KEY_CLEAR  = {DIGITS{NO_DIGIT}};
  localparam logic [3:0]    CNT_FULL   = 4'(DIGITS);
  localparam logic [3:0]    FAIL_LIMIT = 4'(MAX_FAIL);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYC - 1);

  state_e          state_q;
  logic [KW-1:0]   key_q, secret_q, key_d;
  logic [3:0]      digit_cnt_q, cnt_d;
  logic [3:0]      fail_cnt_q, fail_d;
  logic [TW-1:0]   timer_q;
  logic            lock_q, alarm_q, reject_q;
  logic            press_vld;
  logic [3:0]      press_digit;

  tenkey_dec u_dec (
    .ck    (ck),
    .reset (reset),
    .tenkey(tenkey),
    .valid (press_vld),
    .digit (press_digit)
  );

  always_comb begin
    key_d  = (key_q << 4) | KW'(press_digit);
    cnt_d  = (digit_cnt_q == CNT_FULL) ? digit_cnt_q : digit_cnt_q + 4'd1;
    fail_d = fail_cnt_q + 4'd1;
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state_q     <= OPEN;
      key_q       <= KEY_CLEAR;
      secret_q    <= KEY_CLEAR;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
      timer_q     <= '0;
      lock_q      <= 1'b0;
      alarm_q     <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      case (state_q)
        OPEN: begin
          // close takes priority over a press arriving in the same cycle
          if (close) begin
            if (digit_cnt_q == CNT_FULL) begin
              secret_q    <= key_q;
              key_q       <= KEY_CLEAR;
              digit_cnt_q <= '0;
              state_q     <= LOCKED;
              lock_q      <= 1'b1;
            end else begin
              reject_q <= 1'b1;
            end
          end else if (press_vld) begin
            key_q       <= key_d;
            digit_cnt_q <= cnt_d;
          end
        end
        LOCKED: begin
          if (press_vld) begin
            if (cnt_d == CNT_FULL) begin
              digit_cnt_q <= '0;
              if (key_d == secret_q) begin
                key_q      <= key_d;
                state_q    <= OPEN;
                lock_q     <= 1'b0;
                fail_cnt_q <= '0;
              end else begin
                key_q      <= KEY_CLEAR;
                fail_cnt_q <= fail_d;
                if (fail_d == FAIL_LIMIT) begin
                  state_q <= LOCKOUT;
                  timer_q <= TIMER_LOAD;
                  alarm_q <= 1'b1;
                end
              end
            end else begin
              key_q       <= key_d;
              digit_cnt_q <= cnt_d;
            end
          end
        end
        LOCKOUT: begin
          if (timer_q == '0) begin
            state_q    <= LOCKED;
            alarm_q    <= 1'b0;
            fail_cnt_q <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= OPEN;
          lock_q  <= 1'b0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign lock      = lock_q;
  assign alarm     = alarm_q;
  assign reject    = reject_q;
  assign digit_cnt = digit_cnt_q;

endmodule

// File: tb/tb_elelock3.sv
// Bench for elelock3: digit-list reference model compared every cycle, plus directed literal checks.
module tb_elelock3;

  localparam int DIGITS      = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 16;

  localparam int M_OPEN    = 0;
  localparam int M_LOCKED  = 1;
  localparam int M_LOCKOUT = 2;

  logic       ck;
  logic       reset;
  logic [9:0] tenkey;
  logic       close;
  logic       lock, alarm, reject;
  logic [3:0] digit_cnt;

  int checks = 0;
  int errors = 0;

  elelock3 #(.DIGITS(DIGITS), .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCKOUT_CYC)) dut (
    .ck       (ck),
    .reset    (reset),
    .tenkey   (tenkey),
    .close    (close),
    .lock     (lock),
    .alarm    (alarm),
    .reject   (reject),
    .digit_cnt(digit_cnt)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: digits kept as integer lists, lockout as cycles remaining.
  int         m_st, m_cnt, m_fail, m_left;
  bit         m_rej, m_valid;
  logic [9:0] m_prev;
  int         hist[$];
  int         sec[$];

  function automatic bit hist_matches();
    if (hist.size() != sec.size()) return 1'b0;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i] != sec[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge ck) begin
    logic [9:0] pr;
    bit         ok;
    int         dg;
    if (reset) begin
      m_st = M_OPEN; m_cnt = 0; m_fail = 0; m_left = 0; m_rej = 0;
      m_prev = '0; hist.delete(); sec.delete(); m_valid = 1;
    end else begin
      pr = tenkey & ~m_prev;
      ok = ($countones(pr) == 1) && ($countones(tenkey) == 1);
      dg = 0;
      for (int i = 0; i < 10; i++) if (tenkey[i]) dg = i;
      m_rej = 0;
      if (m_st == M_OPEN) begin
        if (close) begin
          if (m_cnt == DIGITS) begin
            sec = hist; hist.delete(); m_cnt = 0; m_st = M_LOCKED;
          end else m_rej = 1;
        end else if (ok) begin
          hist.push_back(dg);
          if (hist.size() > DIGITS) void'(hist.pop_front());
          if (m_cnt < DIGITS) m_cnt++;
        end
      end else if (m_st == M_LOCKED) begin
        if (ok) begin
          hist.push_back(dg);
          if (hist.size() > DIGITS) void'(hist.pop_front());
          m_cnt++;
          if (m_cnt == DIGITS) begin
            m_cnt = 0;
            if (hist_matches()) begin
              m_st = M_OPEN; m_fail = 0;
            end else begin
              hist.delete(); m_fail++;
              if (m_fail == MAX_FAIL) begin m_st = M_LOCKOUT; m_left = LOCKOUT_CYC; end
            end
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) begin m_st = M_LOCKED; m_fail = 0; end
      end
      m_prev = tenkey;
    end
  end

  always @(negedge ck) begin
    if (m_valid) begin
      check("model_lock",   int'(lock),      (m_st != M_OPEN) ? 1 : 0);
      check("model_alarm",  int'(alarm),     (m_st == M_LOCKOUT) ? 1 : 0);
      check("model_reject", int'(reject),    int'(m_rej));
      check("model_cnt",    int'(digit_cnt), m_cnt);
    end
  end

  task automatic do_reset();
    reset = 1'b1; tenkey = '0; close = 1'b0;
    repeat (2) @(negedge ck);
    reset = 1'b0;
  endtask

  task automatic press(input int d);
    tenkey = 10'(1 << d);
    @(negedge ck);
    tenkey = '0;
    @(negedge ck);
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic close_cycle();
    close = 1'b1;
    @(negedge ck);
    close = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; tenkey = '0; close = 1'b0;
    @(negedge ck);

    // Set and unlock
    do_reset();
    check("rst_lock", lock, 0);
    check("rst_alarm", alarm, 0);
    check("rst_cnt", digit_cnt, 0);
    enter4(1, 2, 3, 4);
    check("open_cnt4", digit_cnt, 4);
    close_cycle();
    check("closed_lock", lock, 1);
    check("closed_cnt", digit_cnt, 0);
    enter4(5, 1, 2, 3);
    check("wrong_5123_lock", lock, 1);
    press(1); press(2); press(3);
    check("partial_cnt3", digit_cnt, 3);
    press(4);
    check("unlock_1234", lock, 0);

    // Reject, with a press in the same cycle being discarded
    do_reset();
    press(9);
    check("rej_cnt1", digit_cnt, 1);
    close = 1'b1; tenkey = 10'(1 << 3);
    @(negedge ck);
    check("rej_pulse", reject, 1);
    check("rej_lock", lock, 0);
    check("rej_cnt_kept", digit_cnt, 1);
    close = 1'b0; tenkey = '0;
    @(negedge ck);
    check("rej_one_cycle", reject, 0);

    // Held key, multi-key, saturation
    tenkey = 10'(1 << 7);
    repeat (10) @(negedge ck);
    tenkey = '0;
    @(negedge ck);
    check("held_once", digit_cnt, 2);
    tenkey = 10'b0000000110;
    repeat (3) @(negedge ck);
    tenkey = '0;
    @(negedge ck);
    check("multi_ignored", digit_cnt, 2);
    tenkey = 10'h080; @(negedge ck);
    tenkey = 10'h180; @(negedge ck);
    tenkey = 10'h100; @(negedge ck);
    tenkey = '0;      @(negedge ck);
    check("roll_over_keys", digit_cnt, 3);
    press(4); press(5);
    check("cnt_saturate", digit_cnt, 4);

    // Lockout
    do_reset();
    enter4(1, 2, 3, 4);
    close_cycle();
    enter4(9, 9, 9, 9);
    enter4(9, 9, 9, 9);
    press(9); press(9); press(9);
    tenkey = 10'(1 << 9);
    @(negedge ck);
    check("lockout_alarm", alarm, 1);
    n = 0;
    for (int i = 0; i < 40 && alarm; i++) begin
      n++;
      tenkey = (i % 3 == 1) ? 10'h002 : 10'h000;
      @(negedge ck);
    end
    tenkey = '0;
    check("alarm_cycles", n, 16);
    check("after_lockout_lock", lock, 1);
    check("after_lockout_cnt", digit_cnt, 0);
    enter4(1, 2, 3, 4);
    check("after_lockout_unlock", lock, 0);

    // Fail counter cleared by an unlock
    do_reset();
    enter4(1, 2, 3, 4);
    close_cycle();
    enter4(0, 0, 0, 0);
    enter4(0, 0, 0, 0);
    check("two_fail_alarm", alarm, 0);
    enter4(1, 2, 3, 4);
    check("fc_unlock", lock, 0);
    enter4(0, 0, 0, 0);
    enter4(0, 0, 0, 0);
    check("fc_open_alarm", alarm, 0);
    check("fc_open_lock", lock, 0);
    close_cycle();
    check("fc_relock", lock, 1);
    enter4(1, 1, 1, 1);
    check("fc_fail1_alarm", alarm, 0);
    enter4(1, 1, 1, 1);
    check("fc_fail2_alarm", alarm, 0);
    enter4(0, 0, 0, 0);
    check("fc_unlock0000", lock, 0);

    // Reset mid-entry
    do_reset();
    enter4(1, 2, 3, 4);
    close_cycle();
    press(1); press(2);
    check("mid_cnt2", digit_cnt, 2);
    reset = 1'b1;
    @(negedge ck);
    check("mid_rst_lock", lock, 0);
    check("mid_rst_cnt", digit_cnt, 0);
    reset = 1'b0;
    close_cycle();
    check("mid_rst_reject", reject, 1);
    repeat (3) @(negedge ck);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
